regs_wport_arbiter: RTL and testbench

REGS_WPORT_ARBITER -- requirements
Module: regs_wport_arbiter

---
 rtl/regs_wport_arbiter.sv | 112 +++++++++++
 tb/tb_regs_wport_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wport_arbiter.sv
// regs_wport_arbiter
// Two-requester round-robin arbiter in front of a single register-file write
// port. A grant is combinational from the valids and the priority register.
// The accepted request is registered and shows up as a one-cycle write on
// the next cycle. Writes to x0 are accepted but never presented.
//
// Ports
//   clk_i                  clock, rising edge
//   rst_n_i                asynchronous active-low reset
//   req{0,1}_valid_i       requester has a writeback pending
//   req{0,1}_addr_i[4:0]   destination register
//   req{0,1}_data_i[31:0]  write data
//   req{0,1}_ready_o       transfer accepted this cycle
//   write_o                register-file write enable
//   waddr_o[4:0]           register-file write address
//   wdata_o[31:0]          register-file write data
//   conflict_cnt_o[15:0]   saturating count of cycles with both valids high
module regs_wport_arbiter #(
  parameter int PRIO_INIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  input  logic [4:0]  req0_addr_i,
  input  logic [31:0] req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [4:0]  req1_addr_i,
  input  logic [31:0] req1_data_i,
  output logic        req1_ready_o,
  output logic        write_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [15:0] conflict_cnt_o
);

  localparam logic PRIO_RST = (PRIO_INIT != 0) ? 1'b1 : 1'b0;

  logic        r_prio;
  logic        r_write;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic [15:0] r_conflict_cnt;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_conflict;
  logic        w_wr_en;
  logic [4:0]  w_sel_addr;
  logic [31:0] w_sel_data;

  // Readies are gated by reset so nothing is accepted while rst_n_i is low.
  always_comb begin
    w_grant0 = rst_n_i & req0_valid_i & (~req1_valid_i | ~r_prio);
    w_grant1 = rst_n_i & req1_valid_i & (~req0_valid_i |  r_prio);
  end

  assign w_conflict = req0_valid_i & req1_valid_i;

  always_comb begin
    w_sel_addr = req0_addr_i;
    w_sel_data = req0_data_i;
    if (w_grant1) begin
      w_sel_addr = req1_addr_i;
      w_sel_data = req1_data_i;
    end
  end

  // x0 is hardwired to zero, so a grant to it is consumed without a write.
  assign w_wr_en = (w_grant0 | w_grant1) & (w_sel_addr != 5'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_prio <= PRIO_RST;
    end else if (w_grant0) begin
      r_prio <= 1'b1;
    end else if (w_grant1) begin
      r_prio <= 1'b0;
    end
  end

  // Address/data only load on a real write so they hold while write_o is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_write <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else begin
      r_write <= w_wr_en;
      if (w_wr_en) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign req0_ready_o   = w_grant0;
  assign req1_ready_o   = w_grant1;
  assign write_o        = r_write;
  assign waddr_o        = r_waddr;
  assign wdata_o        = r_wdata;
  assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_regs_wport_arbiter.sv
module tb_regs_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0v, r1v;
  logic [4:0]  r0a, r1a;
  logic [31:0] r0d, r1d;
  logic        rdy0, rdy1, wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [15:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: who holds priority, the write expected this cycle, counter
  int          m_prio;
  logic        m_write;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  regs_wport_arbiter #(.PRIO_INIT(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(r0v), .req0_addr_i(r0a), .req0_data_i(r0d), .req0_ready_o(rdy0),
    .req1_valid_i(r1v), .req1_addr_i(r1a), .req1_data_i(r1d), .req1_ready_o(rdy1),
    .write_o(wr), .waddr_o(waddr), .wdata_o(wdata), .conflict_cnt_o(cnt)
  );

  wire [55:0] dut_vec = {rdy0, rdy1, wr, waddr, wdata, cnt};

  function automatic logic exp_ready(input int n);
    if (r0v && r1v) return (m_prio == n);
    return (n == 0) ? r0v : r1v;
  endfunction

  function automatic logic [55:0] exp_vec();
    return {exp_ready(0), exp_ready(1), m_write, m_waddr, m_wdata, m_cnt};
  endfunction

  task automatic model_reset();
    m_prio = 0; m_write = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
  endtask

  // advance one clock and update the model from the inputs held across the edge
  task automatic adv();
    logic g0, g1;
    g0 = exp_ready(0);
    g1 = exp_ready(1);
    @(posedge clk);
    if (r0v && r1v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_write = 1'b0;
    if (g0) begin
      if (r0a != 0) begin m_write = 1'b1; m_waddr = r0a; m_wdata = r0d; end
      m_prio = 1;
    end else if (g1) begin
      if (r1a != 0) begin m_write = 1'b1; m_waddr = r1a; m_wdata = r1d; end
      m_prio = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    r0v = 0; r1v = 0; r0a = '0; r1a = '0; r0d = '0; r1d = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r0v = 1; r1v = 1; r0a = 5'd3; r1a = 5'd4; r0d = $urandom; r1d = $urandom;
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec !== 56'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, 56'd0);
    end
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    end
    adv();
  endtask

  task automatic test_both_valid();
    r0v = 1; r0a = 5'd10; r0d = 32'hAAAA0000;
    r1v = 1; r1a = 5'd20; r1d = 32'hBBBB1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec() || rdy0 !== (i % 2 == 0) || rdy1 !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL both_grant[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      adv();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (cnt !== 16'd4 || wr !== 1'b1 || waddr !== 5'd20 || wdata !== 32'hBBBB1111) begin
      n_fail++; $display("FAIL both_final: got cnt=%0d wr=%b a=%0d d=%h want cnt=4 wr=1 a=20 d=bbbb1111",
                         cnt, wr, waddr, wdata);
    end
    adv();
  endtask

  task automatic test_single_req0();
    r0v = 1; r0a = 5'd5; r0d = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL single_ready: got %h want %h", dut_vec, exp_vec());
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (wr !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL single_write: got %h want %h", dut_vec, exp_vec());
    end
    adv();
    @(negedge clk);
    n_cmp++;
    if (wr !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_after: got wr=%b a=%0d d=%h want wr=0 a=5 d=deadbeef", wr, waddr, wdata);
    end
  endtask

  task automatic test_x0();
    r1v = 1; r1a = 5'd0; r1d = 32'h1234;
    @(negedge clk);
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
      n_fail++; $display("FAIL x0_ready: got r0=%b r1=%b want r0=0 r1=1", rdy0, rdy1);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (wr !== 1'b0 || waddr !== 5'd5 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL x0_nowrite: got %h want %h", dut_vec, exp_vec());
    end
    adv();
    // prio should now be 0: a conflict must grant requester 0
    r0v = 1; r1v = 1; r0a = 5'd1; r1a = 5'd2; r0d = 32'h11; r1d = 32'h22;
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      n_fail++; $display("FAIL x0_prio: got r0=%b r1=%b want r0=1 r1=0", rdy0, rdy1);
    end
    adv();
    idle_inputs();
  endtask

  task automatic test_prio_hold();
    // prio is 1 after the previous grant to requester 0
    r0v = 1; r0a = 5'd9; r0d = 32'h99;
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      n_fail++; $display("FAIL prio_hold_grant: got r0=%b r1=%b want r0=1 r1=0", rdy0, rdy1);
    end
    adv();
    r1v = 1; r1a = 5'd8; r1d = 32'h88;
    @(negedge clk);
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL prio_hold_after: got %h want %h", dut_vec, exp_vec());
    end
    adv();
    idle_inputs();
  endtask

  task automatic test_random();
    logic g0, g1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      g0 = exp_ready(0);
      g1 = exp_ready(1);
      adv();
      // a pending request holds until it is accepted
      if (g0 || !r0v) begin
        r0v = ($urandom_range(0, 3) != 0); r0a = 5'($urandom_range(0, 31)); r0d = $urandom;
      end
      if (g1 || !r1v) begin
        r1v = ($urandom_range(0, 3) != 0); r1a = 5'($urandom_range(0, 31)); r1d = $urandom;
      end
    end
    idle_inputs();
    adv();
  endtask

  task automatic test_async_reset();
    r0v = 1; r0a = 5'd7; r0d = $urandom;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 56'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec, 56'd0);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wr !== 1'b0 || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL async_release[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      adv();
    end
  endtask

  task automatic test_saturation();
    r0v = 1; r1v = 1; r0a = 5'd3; r1a = 5'd4; r0d = 32'h3; r1d = 32'h4;
    for (int i = 0; i < 65540; i++) adv();
    @(negedge clk);
    n_cmp++;
    if (cnt !== 16'hFFFF || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL sat_reach: got cnt=%h vec=%h want cnt=ffff vec=%h", cnt, dut_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      adv();
      @(negedge clk);
      n_cmp++;
      if (cnt !== 16'hFFFF) begin
        n_fail++; $display("FAIL sat_hold[%0d]: got %h want ffff", i, cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_both_valid();
    test_single_req0();
    test_x0();
    test_prio_hold();
    test_random();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
